// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and geometry for the L2 line <-> memory burst adaptor.
package rv32i_types;

  localparam int s_line    = 256;
  localparam int s_burst   = 64;
  localparam int num_beats = s_line / s_burst;
  localparam int s_offset  = 5;
  localparam int beat_w    = $clog2(num_beats);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } line_burst_state_t;

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Bus bundles for the adaptor: the L2 line side and the physical memory side.
// On the line side the cache is master; on the memory side the adaptor is master.
interface line_burst_line_if;
  logic                           line_read_i;
  logic                           line_write_i;
  logic [31:0]                    line_address_i;
  logic [rv32i_types::s_line-1:0] line_wdata_i;
  logic [rv32i_types::s_line-1:0] line_rdata_o;
  logic                           line_resp_o;

  modport master (
    output line_read_i, line_write_i, line_address_i, line_wdata_i,
    input  line_rdata_o, line_resp_o
  );
  modport slave (
    input  line_read_i, line_write_i, line_address_i, line_wdata_i,
    output line_rdata_o, line_resp_o
  );
endinterface

interface line_burst_mem_if;
  logic [31:0]                     mem_address_o;
  logic                            mem_read_o;
  logic                            mem_write_o;
  logic [rv32i_types::s_burst-1:0] mem_burst_o;
  logic [rv32i_types::s_burst-1:0] mem_burst_i;
  logic                            mem_resp_i;

  modport master (
    output mem_address_o, mem_read_o, mem_write_o, mem_burst_o,
    input  mem_burst_i, mem_resp_i
  );
  modport slave (
    input  mem_address_o, mem_read_o, mem_write_o, mem_burst_o,
    output mem_burst_i, mem_resp_i
  );
endinterface

// File: rtl/line_burst_adaptor_beat_counter.sv
// Modulo-num_beats beat index with increment enable, synchronous clear and a
// last-beat flag. num_beats must be a power of two so the wrap is free.
module line_beat_counter #(
  parameter int num_beats = rv32i_types::num_beats
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         inc_i,
  output logic [$clog2(num_beats)-1:0] count_o,
  output logic                         last_o
);

  localparam int cnt_w = $clog2(num_beats);

  logic [cnt_w-1:0] count_reg;

  // Beat index: cleared by reset or clear, otherwise wraps naturally on increment.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_reg <= '0;
    end else if (inc_i) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count_o = count_reg;
  assign last_o  = (count_reg == cnt_w'(num_beats - 1));

endmodule

// File: rtl/line_burst_adaptor.sv
// Converts one 256-bit line request into a 4-beat 64-bit memory burst and
// reassembles read bursts into a full line for the L2 cache.
module line_burst_adaptor
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  line_burst_line_if.slave  line_bus,
  line_burst_mem_if.master  mem_bus
);

  line_burst_state_t state_reg, state_next;

  logic [31:0]       addr_reg;
  logic [s_line-1:0] wdata_reg;
  logic [s_line-1:0] buf_reg, buf_next;
  logic [s_line-1:0] rdata_reg;
  logic [31:0]       aligned_addr;
  logic [beat_w-1:0] beat_cnt;
  logic              beat_last;
  logic              in_burst;
  logic              beat_ack;
  logic              accept_wr;
  logic              accept_rd;

  // Write wins if both requests are raised together.
  assign accept_wr    = (state_reg == IDLE) && line_bus.line_write_i;
  assign accept_rd    = (state_reg == IDLE) && !line_bus.line_write_i && line_bus.line_read_i;
  assign in_burst     = (state_reg == RD_BURST) || (state_reg == WR_BURST);
  assign beat_ack     = in_burst && mem_bus.mem_resp_i;
  assign aligned_addr = {line_bus.line_address_i[31:s_offset], {s_offset{1'b0}}};

  line_beat_counter #(.num_beats(num_beats)) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_reg == IDLE),
    .inc_i   (beat_ack),
    .count_o (beat_cnt),
    .last_o  (beat_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: bursts end on the acknowledged last beat, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept_wr)      state_next = WR_BURST;
        else if (accept_rd) state_next = RD_BURST;
      end
      RD_BURST, WR_BURST: begin
        if (beat_ack && beat_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: memory side is quiet (all zero) outside the burst states.
  always_comb begin
    mem_bus.mem_read_o    = 1'b0;
    mem_bus.mem_write_o   = 1'b0;
    mem_bus.mem_address_o = '0;
    mem_bus.mem_burst_o   = '0;
    line_bus.line_resp_o  = 1'b0;
    unique case (state_reg)
      RD_BURST: begin
        mem_bus.mem_read_o    = 1'b1;
        mem_bus.mem_address_o = addr_reg;
      end
      WR_BURST: begin
        mem_bus.mem_write_o   = 1'b1;
        mem_bus.mem_address_o = addr_reg;
        mem_bus.mem_burst_o   = wdata_reg[s_burst*beat_cnt +: s_burst];
      end
      DONE:    line_bus.line_resp_o = 1'b1;
      default: ;
    endcase
  end

  // Line buffer with the incoming beat merged into slot beat_cnt.
  always_comb begin
    buf_next = buf_reg;
    buf_next[s_burst*beat_cnt +: s_burst] = mem_bus.mem_burst_i;
  end

  // Request latches, partial-line buffer and the published read line.
  // The published line only changes when a read's final beat lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      buf_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      if (accept_wr) begin
        addr_reg  <= aligned_addr;
        wdata_reg <= line_bus.line_wdata_i;
      end else if (accept_rd) begin
        addr_reg  <= aligned_addr;
      end
      if ((state_reg == RD_BURST) && mem_bus.mem_resp_i) begin
        buf_reg <= buf_next;
        if (beat_last) rdata_reg <= buf_next;
      end
    end
  end

  assign line_bus.line_rdata_o = rdata_reg;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed + randomized bench for line_burst_adaptor with a behavioural memory
// and line model; one line per transaction plus one summary line.
module tb_line_burst_adaptor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  line_burst_line_if lif ();
  line_burst_mem_if  mif ();

  line_burst_adaptor dut (
    .clk      (clk),
    .rst      (rst),
    .line_bus (lif.slave),
    .mem_bus  (mif.master)
  );

  int errors = 0;
  int checks = 0;
  logic [255:0] model_rdata = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One line transaction. Memory acks follow pat (LSB first) for pat_len cycles,
  // then random (rnd) or always-1. seq_data gives beats 0x1111.., 0x2222.., ...
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [31:0] pat,
                         input int pat_len, input bit rnd, input bit seq_data);
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    logic [63:0]  beat_data;
    logic [3:0]   nib;
    int           beats;
    int           cyc;
    bit           ack;
    exp_line = '0;
    exp_addr = addr & 32'hFFFF_FFE0;
    @(negedge clk);
    lif.line_read_i    = rd;
    lif.line_write_i   = wr;
    lif.line_address_i = addr;
    lif.line_wdata_i   = wdata;
    @(negedge clk);
    // Scramble the request inputs: the adaptor must use its latched copies.
    lif.line_address_i = $urandom;
    lif.line_wdata_i   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 100) begin
      check("mem_read", mif.mem_read_o, !wr);
      check("mem_write", mif.mem_write_o, wr);
      check("mem_addr", mif.mem_address_o, exp_addr);
      check("resp_mid", lif.line_resp_o, 1'b0);
      if (wr) check("wr_beat", mif.mem_burst_o, wdata[64*beats +: 64]);
      ack = (cyc < pat_len) ? pat[cyc] : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      nib = 4'(beats + 1);
      beat_data = seq_data ? {16{nib}} : {$urandom, $urandom};
      mif.mem_resp_i  = ack;
      mif.mem_burst_i = beat_data;
      @(posedge clk);
      if (ack) begin
        exp_line[64*beats +: 64] = beat_data;
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    mif.mem_resp_i  = 1'b0;
    mif.mem_burst_i = {$urandom, $urandom};
    check("beat_budget", 256'(beats), 256'd4);
    if (!wr) model_rdata = exp_line;
    // DONE cycle: one cycle after the final ack.
    check("resp_done", lif.line_resp_o, 1'b1);
    check("read_done", mif.mem_read_o, 1'b0);
    check("write_done", mif.mem_write_o, 1'b0);
    check("rdata_done", lif.line_rdata_o, model_rdata);
    lif.line_read_i  = 1'b0;
    lif.line_write_i = 1'b0;
    @(negedge clk);
    check("resp_idle", lif.line_resp_o, 1'b0);
    check("read_idle", mif.mem_read_o, 1'b0);
    check("write_idle", mif.mem_write_o, 1'b0);
    check("rdata_idle", lif.line_rdata_o, model_rdata);
    $display("txn rd=%0b wr=%0b addr=%h cycles=%0d beats=%0d errors=%0d", rd, wr, addr, cyc, beats, errors);
  endtask

  initial begin
    logic [255:0] wd;
    logic [31:0]  a;
    bit           r;
    bit           w;
    lif.line_read_i    = 1'b0;
    lif.line_write_i   = 1'b0;
    lif.line_address_i = '0;
    lif.line_wdata_i   = '0;
    mif.mem_resp_i     = 1'b0;
    mif.mem_burst_i    = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp", lif.line_resp_o, 1'b0);
    check("rst_read", mif.mem_read_o, 1'b0);
    check("rst_write", mif.mem_write_o, 1'b0);
    check("rst_addr", mif.mem_address_o, 32'h0);
    check("rst_burst", mif.mem_burst_o, 64'h0);
    check("rst_rdata", lif.line_rdata_o, 256'h0);
    rst = 1'b0;

    // Read, no stalls, sequential beat data.
    run_txn(1'b1, 1'b0, 32'h0000_0047, '0, 32'h0, 0, 1'b0, 1'b1);
    check("seq_line", lif.line_rdata_o,
          {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

    // Write, no stalls.
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(1'b0, 1'b1, 32'h1234_567F, wd, 32'h0, 0, 1'b0, 1'b0);

    // Stalled read: acks 1,0,0,1,0,1,1.
    run_txn(1'b1, 1'b0, 32'h8000_0020, '0, 32'b1101001, 7, 1'b0, 1'b0);

    // Simultaneous read and write: write wins.
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(1'b1, 1'b1, 32'h0000_1000, wd, 32'h0, 0, 1'b1, 1'b0);

    // mem_resp_i in IDLE is ignored.
    mif.mem_resp_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_read", mif.mem_read_o, 1'b0);
      check("idle_ack_resp", lif.line_resp_o, 1'b0);
    end
    mif.mem_resp_i = 1'b0;

    // Reset after two beats of a read.
    @(negedge clk);
    lif.line_read_i    = 1'b1;
    lif.line_address_i = 32'h0000_2040;
    @(negedge clk);
    repeat (2) begin
      mif.mem_resp_i  = 1'b1;
      mif.mem_burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    mif.mem_resp_i  = 1'b0;
    lif.line_read_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    check("mrst_resp", lif.line_resp_o, 1'b0);
    check("mrst_read", mif.mem_read_o, 1'b0);
    check("mrst_write", mif.mem_write_o, 1'b0);
    check("mrst_addr", mif.mem_address_o, 32'h0);
    check("mrst_rdata", lif.line_rdata_o, 256'h0);
    @(negedge clk);
    check("mrst_resp2", lif.line_resp_o, 1'b0);
    $display("txn reset mid-read errors=%0d", errors);
    run_txn(1'b1, 1'b0, 32'h0000_2040, '0, 32'h0, 0, 1'b1, 1'b0);

    // Back-to-back read then write at the top line.
    run_txn(1'b1, 1'b0, 32'hFFFF_FFE0, '0, 32'h0, 0, 1'b0, 1'b0);
    wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(1'b0, 1'b1, 32'hFFFF_FFE0, wd, 32'h0, 0, 1'b0, 1'b0);

    // Randomized mix with random stalls.
    for (int i = 0; i < 12; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = r ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(r, w, a, wd, 32'h0, 0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
